// File: rtl/axi_superset_pkg.sv
// Shared types for the AXI superset write-path checker.
// Beat counts are 9 bits so a 256-beat burst is representable.
package axi_superset_pkg;

  typedef logic [8:0] wr_chk_beats_t;

  typedef enum logic [1:0] {
    WR_CHK_ERR_LEN     = 2'd0,
    WR_CHK_ERR_ORPHAN  = 2'd1,
    WR_CHK_ERR_OVF     = 2'd2,
    WR_CHK_ERR_TIMEOUT = 2'd3
  } wr_chk_err_e;

  localparam wr_chk_beats_t WR_CHK_MAX_BEATS = 9'd256;

endpackage

// File: rtl/axi_superset_wr_chk_fifo.sv
// Small synchronous FIFO used for AW lengths and W burst counts.
// A push into a full FIFO is dropped unless a pop happens the same cycle.
module axi_superset_wr_chk_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_superset_wr_checker.sv
// Passive AW/W/B write-path checker for the AXI superset bus.
// Optional B timeout: AXI_SUPERSET_WR_CHECKER_TIMEOUT_EN.
module axi_superset_wr_checker
  import axi_superset_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             aw_valid_i,
  input  logic             aw_ready_i,
  input  logic [7:0]       aw_len_i,
  input  logic             w_valid_i,
  input  logic             w_ready_i,
  input  logic             w_last_i,
  input  logic             b_valid_i,
  input  logic             b_ready_i,
  output logic             err_len_o,
  output logic             err_orphan_b_o,
  output logic             err_ovf_o,
  output logic             err_timeout_o,
  output logic [3:0]       err_sticky_o,
  output logic [CNT_W-1:0] outstanding_o
);

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign aw_hs = aw_valid_i & aw_ready_i;
  assign w_hs  = w_valid_i & w_ready_i;
  assign b_hs  = b_valid_i & b_ready_i;

  wr_chk_beats_t beat_q;
  wr_chk_beats_t beat_d;
  wr_chk_beats_t beat_inc;
  wr_chk_beats_t aw_beats;
  wr_chk_beats_t aw_head;
  wr_chk_beats_t w_head;

  logic aw_full, aw_empty;
  logic w_full, w_empty;
  logic w_push;
  logic wrap_err;
  logic match;

  assign aw_beats = wr_chk_beats_t'(aw_len_i) + 9'd1;
  assign match    = ~aw_empty & ~w_empty;

  // A 257th beat cannot belong to any legal burst: flag it and restart at 1.
  always_comb begin
    wrap_err = 1'b0;
    w_push   = 1'b0;
    beat_d   = beat_q;
    beat_inc = beat_q + 9'd1;
    if (w_hs) begin
      if (beat_q == WR_CHK_MAX_BEATS) begin
        wrap_err = 1'b1;
        beat_inc = 9'd1;
      end
      w_push = w_last_i;
      beat_d = w_last_i ? '0 : beat_inc;
    end
  end

  axi_superset_wr_chk_fifo #(
    .DEPTH (DEPTH),
    .W     (9)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (aw_hs),
    .pop     (match),
    .din     (aw_beats),
    .head    (aw_head),
    .full    (aw_full),
    .empty   (aw_empty)
  );

  axi_superset_wr_chk_fifo #(
    .DEPTH (DEPTH),
    .W     (9)
  ) u_w_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (w_push),
    .pop     (match),
    .din     (beat_inc),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  logic [CNT_W-1:0] out_q;
  logic [CNT_W-1:0] out_d;
  logic             dec;
  logic             cnt_ovf;
  logic             orphan_d;
  logic             len_d;
  logic             ovf_d;
  logic             to_d;

  assign dec      = b_hs & ((out_q != '0) | match);
  assign orphan_d = b_hs & ~dec;

  always_comb begin
    out_d   = out_q;
    cnt_ovf = 1'b0;
    unique case (1'b1)
      match & ~dec: begin
        if (out_q == {CNT_W{1'b1}}) cnt_ovf = 1'b1;
        else out_d = out_q + 1'b1;
      end
      dec & ~match: out_d = out_q - 1'b1;
      default: ;
    endcase
  end

  assign len_d = (match & (aw_head != w_head)) | wrap_err;
  assign ovf_d = (aw_hs & aw_full & ~match) |
                 (w_push & w_full & ~match) |
                 cnt_ovf;

`ifdef AXI_SUPERSET_WR_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_q;

  assign to_d = ~b_hs & (out_q != '0) &&
                (timer_q == TW'(TIMEOUT - 1));

  // Holds at TIMEOUT so the pulse fires once per wait.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_q <= '0;
    end else if (b_hs || (out_q == '0)) begin
      timer_q <= '0;
    end else if (timer_q != TW'(TIMEOUT)) begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign to_d = (TIMEOUT < 0);
`endif

  logic [3:0] pulse_d;

  always_comb begin
    pulse_d = '0;
    pulse_d[WR_CHK_ERR_LEN]     = len_d;
    pulse_d[WR_CHK_ERR_ORPHAN]  = orphan_d;
    pulse_d[WR_CHK_ERR_OVF]     = ovf_d;
    pulse_d[WR_CHK_ERR_TIMEOUT] = to_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      beat_q         <= '0;
      out_q          <= '0;
      err_len_o      <= 1'b0;
      err_orphan_b_o <= 1'b0;
      err_ovf_o      <= 1'b0;
      err_timeout_o  <= 1'b0;
      err_sticky_o   <= '0;
    end else begin
      beat_q         <= beat_d;
      out_q          <= out_d;
      err_len_o      <= len_d;
      err_orphan_b_o <= orphan_d;
      err_ovf_o      <= ovf_d;
      err_timeout_o  <= to_d;
      err_sticky_o   <= err_sticky_o | pulse_d;
    end
  end

  assign outstanding_o = out_q;

endmodule

// File: tb/tb_axi_superset_wr_checker.sv
// Scoreboard bench for axi_superset_wr_checker.
// Optional timeout case: AXI_SUPERSET_WR_CHECKER_TIMEOUT_EN.
module tb_axi_superset_wr_checker;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       aw_valid_i = 1'b0;
  logic       aw_ready_i = 1'b0;
  logic [7:0] aw_len_i = '0;
  logic       w_valid_i = 1'b0;
  logic       w_ready_i = 1'b0;
  logic       w_last_i = 1'b0;
  logic       b_valid_i = 1'b0;
  logic       b_ready_i = 1'b0;
  logic       err_len_o;
  logic       err_orphan_b_o;
  logic       err_ovf_o;
  logic       err_timeout_o;
  logic [3:0] err_sticky_o;
  logic [7:0] outstanding_o;

  axi_superset_wr_checker #(
    .DEPTH   (8),
    .CNT_W   (8),
    .TIMEOUT (16)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .aw_valid_i     (aw_valid_i),
    .aw_ready_i     (aw_ready_i),
    .aw_len_i       (aw_len_i),
    .w_valid_i      (w_valid_i),
    .w_ready_i      (w_ready_i),
    .w_last_i       (w_last_i),
    .b_valid_i      (b_valid_i),
    .b_ready_i      (b_ready_i),
    .err_len_o      (err_len_o),
    .err_orphan_b_o (err_orphan_b_o),
    .err_ovf_o      (err_ovf_o),
    .err_timeout_o  (err_timeout_o),
    .err_sticky_o   (err_sticky_o),
    .outstanding_o  (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] err;
  } exp_t;

  exp_t exp_q[$];

  function automatic void expect_pulse(int c, logic [3:0] e);
    exp_t x;
    x.cyc = c;
    x.err = e;
    exp_q.push_back(x);
  endfunction

  // Pulse vector is {timeout, ovf, orphan, len}.
  always @(negedge clk_i) begin
    logic [3:0] act;
    exp_t       e;
    act = {err_timeout_o, err_ovf_o, err_orphan_b_o, err_len_o};
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_pulse", 32'(act), 32'(e.err));
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("pulse", 32'(act), 32'(e.err));
    end else if (act != 4'b0) begin
      check("spurious_pulse", 32'(act), 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic aw(input logic [7:0] len);
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    aw_len_i   = len;
    @(posedge clk_i);
    #1;
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
  endtask

  task automatic wb(input logic last);
    w_valid_i = 1'b1;
    w_ready_i = 1'b1;
    w_last_i  = last;
    @(posedge clk_i);
    #1;
    w_valid_i = 1'b0;
    w_ready_i = 1'b0;
    w_last_i  = 1'b0;
  endtask

  task automatic b();
    b_valid_i = 1'b1;
    b_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    b_valid_i = 1'b0;
    b_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_sticky;
    int h;
    exp_sticky = 4'b0000;

    idle(3);
    check("reset_out", 32'(outstanding_o), 32'h0);
    check("reset_sticky", 32'(err_sticky_o), 32'h0);
    check("reset_pulses",
          32'({err_timeout_o, err_ovf_o, err_orphan_b_o, err_len_o}), 32'h0);
    reset_i = 1'b0;
    idle(2);

    // matched 4-beat burst
    aw(8'd3);
    wb(1'b0); wb(1'b0); wb(1'b0); wb(1'b1);
    check("good_out_pre", 32'(outstanding_o), 32'h0);
    idle(1);
    check("good_out_1", 32'(outstanding_o), 32'h1);
    b();
    check("good_out_0", 32'(outstanding_o), 32'h0);
    idle(2);
    check("good_sticky", 32'(err_sticky_o), 32'h0);

    // short burst
    aw(8'd3);
    wb(1'b0); wb(1'b0);
    expect_pulse(cyc + 2, 4'b0001);
    wb(1'b1);
    idle(3);
    check("len_out", 32'(outstanding_o), 32'h1);
    check("len_sticky", 32'(err_sticky_o), 32'h1);
    b();
    check("len_out_b", 32'(outstanding_o), 32'h0);

    // W leads AW by two bursts
    wb(1'b0); wb(1'b1);
    wb(1'b1);
    idle(2);
    check("lead_out_0", 32'(outstanding_o), 32'h0);
    aw(8'd1);
    aw(8'd0);
    idle(2);
    check("lead_out_2", 32'(outstanding_o), 32'h2);
    b();
    check("lead_out_1", 32'(outstanding_o), 32'h1);
    b();
    check("lead_out_b", 32'(outstanding_o), 32'h0);

    // orphan B at idle
    idle(2);
    expect_pulse(cyc + 1, 4'b0010);
    b();
    check("orphan_out", 32'(outstanding_o), 32'h0);
    check("orphan_sticky", 32'(err_sticky_o), 32'h3);

    // AW FIFO overflow on the 9th push only
    for (int i = 0; i < 9; i++) begin
      if (i == 8) expect_pulse(cyc + 1, 4'b0100);
      aw(8'd0);
    end
    idle(2);
    check("ovf_sticky", 32'(err_sticky_o), 32'h7);
    check("ovf_out", 32'(outstanding_o), 32'h0);

    // reset with a full AW FIFO
    reset_i = 1'b1;
    #1;
    check("rst_sticky", 32'(err_sticky_o), 32'h0);
    check("rst_out", 32'(outstanding_o), 32'h0);
    idle(2);
    reset_i = 1'b0;
    idle(1);
    wb(1'b1);
    idle(2);
    check("rst_fifo_empty", 32'(outstanding_o), 32'h0);
    aw(8'd0);
    idle(2);
    check("rst_match", 32'(outstanding_o), 32'h1);
    b();
    check("rst_match_b", 32'(outstanding_o), 32'h0);

    // match and B in the same cycle
    aw(8'd0);
    wb(1'b1);
    b();
    check("same_cyc_out", 32'(outstanding_o), 32'h0);
    idle(2);
    check("same_cyc_out2", 32'(outstanding_o), 32'h0);
    check("same_cyc_sticky", 32'(err_sticky_o), 32'h0);

`ifdef AXI_SUPERSET_WR_CHECKER_TIMEOUT_EN
    aw(8'd0);
    wb(1'b1);
    h = cyc;
    expect_pulse(h + 17, 4'b1000);
    idle(22);
    check("to_out", 32'(outstanding_o), 32'h1);
    b();
    check("to_out_b", 32'(outstanding_o), 32'h0);
    idle(20);
    exp_sticky = 4'b1000;
`else
    h = 0;
`endif

    idle(3);
    check("final_sticky", 32'(err_sticky_o), 32'(exp_sticky));
    check("pending", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
